// File: rtl/spi_block_ctrl.sv
// Block-transfer sequencer: streams NUM_BYTES bytes through a byte-wide SPI master, collecting replies.
// Optional inter-byte idle gap via SPI_BLOCK_CTRL_GAP_EN (GAP_CYCLES idle cycles after each non-final byte).
module spi_block_ctrl #(
  parameter int NUM_BYTES  = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [8*NUM_BYTES-1:0] block_in,
  output logic [8*NUM_BYTES-1:0] block_out,
  output logic                   busy,
  output logic                   done,
  output logic                   m_start,
  output logic [7:0]             m_data_in,
  input  logic [7:0]             m_data_out,
  input  logic                   m_buzy,
  input  logic                   m_done
);

  localparam int BW = 8 * NUM_BYTES;
  localparam int CW = $clog2(NUM_BYTES);
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

  if (NUM_BYTES < 2 || NUM_BYTES > 32) begin : g_bad_num_bytes
    $error("spi_block_ctrl: NUM_BYTES out of range 2..32");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap_cycles
    $error("spi_block_ctrl: GAP_CYCLES out of range 1..255");
  end

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
`ifdef SPI_BLOCK_CTRL_GAP_EN
    GAP,
`endif
    FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   tx_q, tx_d;
  logic [BW-1:0]   rx_q, rx_d;
  logic [BW-1:0]   blk_q, blk_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef SPI_BLOCK_CTRL_GAP_EN
  logic [7:0]      gap_q, gap_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    blk_d   = blk_q;
    m_start = 1'b0;
`ifdef SPI_BLOCK_CTRL_GAP_EN
    gap_d   = gap_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          tx_d    = block_in;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      // Strobe is decoded combinationally so the issue costs no extra cycle.
      ISSUE: begin
        if (!m_buzy) begin
          m_start = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (m_done) begin
          rx_d = {rx_q[BW-9:0], m_data_out};
          if (cnt_q == LAST) begin
            blk_d   = rx_d;
            state_d = FINISH;
          end else begin
            cnt_d = cnt_q + 1'b1;
            tx_d  = {tx_q[BW-9:0], 8'h00};
`ifdef SPI_BLOCK_CTRL_GAP_EN
            gap_d   = 8'(GAP_CYCLES - 1);
            state_d = GAP;
`else
            state_d = ISSUE;
`endif
          end
        end
      end
`ifdef SPI_BLOCK_CTRL_GAP_EN
      GAP: begin
        if (gap_q == 8'd0) state_d = ISSUE;
        else               gap_d   = gap_q - 1'b1;
      end
`endif
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including a coincident m_done.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      blk_d   = blk_q;
      m_start = 1'b0;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      blk_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SPI_BLOCK_CTRL_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      blk_q   <= blk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SPI_BLOCK_CTRL_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign block_out = blk_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign m_data_in = tx_q[BW-1 -: 8];

endmodule

// File: tb/tb_spi_block_ctrl.sv
// Directed bench for spi_block_ctrl with a behavioural SPI master/slave model.
module tb_spi_block_ctrl;
  localparam int NB = 16;
  localparam int GC = 4;
`ifdef SPI_BLOCK_CTRL_GAP_EN
  localparam int LAT = GC + 1;
`else
  localparam int LAT = 1;
`endif

  logic         clk, reset, start, abort;
  logic [127:0] block_in, block_out;
  logic         busy, done, m_start;
  logic [7:0]   m_data_in, m_data_out;
  logic         m_buzy, m_done;

  spi_block_ctrl #(.NUM_BYTES(NB), .GAP_CYCLES(GC)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .block_in(block_in), .block_out(block_out), .busy(busy), .done(done),
    .m_start(m_start), .m_data_in(m_data_in), .m_data_out(m_data_out),
    .m_buzy(m_buzy), .m_done(m_done)
  );

  int n_chk = 0, n_err = 0;
  int cyc = 0, done_cnt = 0, mstart_cnt = 0, mdone_cnt = 0;
  int lat_min, lat_max, t_done;
  bit have_done;
  logic echo_mode;
  logic [7:0] fixed_reply, prev_tx, cap;
  logic [7:0] rx_log [0:63];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Master model: strobe seen -> 2 busy cycles -> one-cycle m_done with reply.
  initial begin
    m_buzy = 1'b0; m_done = 1'b0; m_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (m_start) begin
        if (have_done) begin
          if (cyc - t_done < lat_min) lat_min = cyc - t_done;
          if (cyc - t_done > lat_max) lat_max = cyc - t_done;
        end
        cap = m_data_in;
        rx_log[mstart_cnt] = cap;
        mstart_cnt++;
        @(posedge clk); #1 m_buzy = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 m_buzy = 1'b0;
        m_done     = 1'b1;
        m_data_out = echo_mode ? prev_tx : fixed_reply;
        prev_tx    = cap;
        mdone_cnt++;
        t_done     = cyc;
        have_done  = 1'b1;
        @(posedge clk); #1 m_done = 1'b0;
      end
    end
  end

  task automatic run_block(input logic [127:0] data);
    mstart_cnt = 0; mdone_cnt = 0; done_cnt = 0;
    have_done = 1'b0; lat_min = 1000000; lat_max = 0;
    block_in = data;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("done_timeout", ok, 1);
  endtask

  initial begin
    int bad;
    bit ok;
    start = 0; abort = 0; block_in = '0;
    echo_mode = 1'b1; fixed_reply = 8'h00; prev_tx = 8'h00;
    have_done = 1'b0; t_done = 0; lat_min = 0; lat_max = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_m_start", m_start, 0);
    chk("rst_m_data_in", m_data_in, 0);
    chk("rst_block_out", block_out, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Echo loopback: slave returns the previous byte it received.
    echo_mode = 1'b1; prev_tx = 8'h00;
    run_block(128'h00112233445566778899AABBCCDDEEFF);
    wait_done();
    chk("echo_block_out", block_out, 128'h0000112233445566778899AABBCCDDEE);
    chk("echo_busy_at_done", busy, 1);
    @(negedge clk);
    chk("echo_busy_after", busy, 0);
    repeat (10) @(negedge clk);
    chk("echo_m_starts", mstart_cnt, 16);
    chk("echo_dones", done_cnt, 1);
    chk("lat_min", lat_min, LAT);
    chk("lat_max", lat_max, LAT);
    bad = 0;
    for (int i = 0; i < 16; i++) if (rx_log[i] !== 8'(8'h11 * i)) bad++;
    chk("slave_bytes", bad, 0);

    // Fixed reply.
    echo_mode = 1'b0; fixed_reply = 8'hA5;
    run_block(128'h0123456789ABCDEF0F1E2D3C4B5A6978);
    wait_done();
    chk("a5_block_out", block_out, {16{8'hA5}});
    @(negedge clk);
    chk("a5_busy_after", busy, 0);
    repeat (10) @(negedge clk);
    chk("a5_dones", done_cnt, 1);

    // Abort coincident with the 5th m_done.
    fixed_reply = 8'h3C;
    run_block(128'hFFEEDDCCBBAA99887766554433221100);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (mdone_cnt == 5) begin ok = 1'b1; break; end
    end
    chk("abort_wait_timeout", ok, 1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_m_starts", mstart_cnt, 5);
    chk("abort_block_out", block_out, {16{8'hA5}});
    run_block(128'h1);
    wait_done();
    chk("post_abort_block_out", block_out, {16{8'h3C}});
    repeat (10) @(negedge clk);
    chk("post_abort_dones", done_cnt, 1);

    // start pulses while busy are ignored.
    fixed_reply = 8'h5A;
    run_block(128'h2);
    repeat (20) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    start = 1'b1; @(negedge clk); @(negedge clk); start = 1'b0;
    wait_done();
    chk("sib_block_out", block_out, {16{8'h5A}});
    @(negedge clk);
    chk("sib_busy_after", busy, 0);
    repeat (20) @(negedge clk);
    chk("sib_m_starts", mstart_cnt, 16);
    chk("sib_dones", done_cnt, 1);

    // Asynchronous reset in the middle of byte 7.
    fixed_reply = 8'h77;
    run_block(128'h3);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (mstart_cnt == 7) begin ok = 1'b1; break; end
    end
    chk("rst7_wait_timeout", ok, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst7_busy", busy, 0);
    chk("rst7_done", done, 0);
    chk("rst7_m_start", m_start, 0);
    chk("rst7_m_data_in", m_data_in, 0);
    chk("rst7_block_out", block_out, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst7_no_done", done_cnt, 0);
    chk("rst7_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_block_ctrl.md
SPI_BLOCK_CTRL -- requirements
Module: spi_block_ctrl

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 16, bytes per block transfer (2..32).
REQ-002 SHALL have parameter GAP_CYCLES, default 4, idle clk cycles between bytes when the gap feature is enabled (1..255).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request one block transfer.
REQ-006 SHALL have port abort  input  1  cancel the transfer in progress.
REQ-007 SHALL have port block_in  input  8*NUM_BYTES  transmit block; byte 0 is bits [8*NUM_BYTES-1 -: 8].
REQ-008 SHALL have port block_out  output  8*NUM_BYTES  received block, same byte ordering.
REQ-009 SHALL have port busy  output  1  transfer in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse on block completion.
REQ-011 SHALL have port m_start  output  1  start strobe to the SPI master.
REQ-012 SHALL have port m_data_in  output  8  byte to the SPI master.
REQ-013 SHALL have port m_data_out  input  8  byte received by the SPI master.
REQ-014 SHALL have port m_buzy  input  1  SPI master busy.
REQ-015 SHALL have port m_done  input  1  SPI master one-cycle byte-complete pulse.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, GAP, FINISH.
REQ-017 IDLE: when start=1 and abort=0, SHALL latch block_in into the tx shift register, clear the byte counter, and enter ISSUE next cycle.
REQ-018 ISSUE: while m_buzy=1, SHALL hold; when m_buzy=0, SHALL drive m_start=1 for exactly one cycle with m_data_in = current tx byte, then enter WAIT.
REQ-019 WAIT: on m_done=1, SHALL shift m_data_out into the rx shift register (byte 0 first); if counter=NUM_BYTES-1, SHALL enter FINISH; otherwise SHALL increment the counter, advance the tx byte, and enter GAP (feature enabled) or ISSUE (disabled).
REQ-020 GAP: SHALL remain exactly GAP_CYCLES cycles, then enter ISSUE.
REQ-021 FINISH: SHALL copy the rx register into block_out, pulse done for one cycle in the same cycle, and return to IDLE.
REQ-022 busy SHALL be 1 in every state except IDLE, and SHALL be 0 in the cycle after done.
REQ-023 start while busy=1 SHALL be ignored; start held high in FINISH SHALL NOT restart until IDLE samples it.
REQ-024 abort=1 in any non-IDLE state SHALL force IDLE next cycle, with no done pulse, block_out unchanged, and the counter cleared; abort has priority over m_done in the same cycle.
REQ-025 m_done outside WAIT SHALL be ignored; m_data_in SHALL hold the current tx byte whenever busy=1.
REQ-026 Zero-gap latency (m_buzy low at issue): ISSUE to m_start is 0 cycles and m_done to the next m_start is 1 cycle.

Reset
REQ-027 With reset=0, asynchronously: state=IDLE, busy=0, done=0, m_start=0, m_data_in=0, block_out=0, counter=0, gap counter=0, shift registers=0.
REQ-028 Reset during a transfer SHALL discard it with no done pulse; operation resumes on the first edge after reset=1.

Configuration
REQ-029 Macro SPI_BLOCK_CTRL_GAP_EN defined: the GAP state SHALL be inserted between bytes per REQ-020.
REQ-030 Macro SPI_BLOCK_CTRL_GAP_EN undefined: the GAP state and its counter SHALL NOT exist, and WAIT SHALL go directly to ISSUE; GAP_CYCLES is then unused.

Verification
REQ-031 Loopback with an 8-bit SPI master and slave, slave echoing the previous byte; block_in=128'h00112233445566778899AABBCCDDEEFF -> exactly 16 m_start pulses, one done, slave receives bytes 00..FF in order.
REQ-032 Fixed slave reply 8'hA5 -> block_out=128'hA5A5...A5 at done, and busy falls the cycle after.
REQ-033 abort asserted after the 5th m_done -> no done, busy=0 next cycle, block_out keeps its previous value; a following start completes normally.
REQ-034 reset=0 asynchronously mid-byte 7 -> all outputs at reset values immediately, and no done pulse.
REQ-035 GAP_EN defined with GAP_CYCLES=4 -> exactly 5 cycles from each m_done to the next m_start; undefined -> exactly 1 cycle.
REQ-036 start pulsed while busy -> ignored, exactly 16 m_start pulses, one done.
